axi_default_slave: RTL

- AXI4 responder for every transaction the address decoder routes to the default-slave port, i.e. any access outside the ROM, IM, DM, DMA, WDT or DRAM windows.
- Completes each write and read burst with a DECERR response so the initiating master never hangs.
- Sits on the bridge's SDEFAULT slave port and answers the VALID_SDEFAULT / READY_SDEFAULT path.
- Write and read channels are fully independent.

---
 rtl/axi_default_slave.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axi_default_slave.sv
// AXI4 default slave: accepts every write/read burst routed outside the mapped
// windows and completes it with a DECERR response. Write and read sides are independent.
module axi_default_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    // write address
    input  logic [ID_W-1:0]   AWID_S,
    input  logic [ADDR_W-1:0] AWADDR_S,
    input  logic [LEN_W-1:0]  AWLEN_S,
    input  logic [2:0]        AWSIZE_S,
    input  logic [1:0]        AWBURST_S,
    input  logic              AWVALID_S,
    output logic              AWREADY_S,
    // write data
    input  logic [DATA_W-1:0]   WDATA_S,
    input  logic [DATA_W/8-1:0] WSTRB_S,
    input  logic                WLAST_S,
    input  logic                WVALID_S,
    output logic                WREADY_S,
    // write response
    output logic [ID_W-1:0]   BID_S,
    output logic [1:0]        BRESP_S,
    output logic              BVALID_S,
    input  logic              BREADY_S,
    // read address
    input  logic [ID_W-1:0]   ARID_S,
    input  logic [ADDR_W-1:0] ARADDR_S,
    input  logic [LEN_W-1:0]  ARLEN_S,
    input  logic [2:0]        ARSIZE_S,
    input  logic [1:0]        ARBURST_S,
    input  logic              ARVALID_S,
    output logic              ARREADY_S,
    // read data
    output logic [ID_W-1:0]   RID_S,
    output logic [DATA_W-1:0] RDATA_S,
    output logic [1:0]        RRESP_S,
    output logic              RLAST_S,
    output logic              RVALID_S,
    input  logic              RREADY_S
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [1:0]       w_state;
    logic [0:0]       r_state;
    logic [LEN_W-1:0] aw_len_dbg;   // captured burst length, visible to debug probes only
    logic [LEN_W-1:0] ar_len;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] beat_cnt_next;

    assign beat_cnt_next = beat_cnt + LEN_W'(1);

    // Write side: AW -> W beats until WLAST -> B. Data is dropped; AWLEN never ends the burst.
    // NOTE: every register is updated with <= so all state moves together on the clock edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state    <= W_IDLE;
            AWREADY_S  <= 1'b0;
            WREADY_S   <= 1'b0;
            BVALID_S   <= 1'b0;
            BID_S      <= '0;
            BRESP_S    <= RESP_DECERR;
            aw_len_dbg <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID_S && AWREADY_S) begin
                        w_state    <= W_DATA;
                        AWREADY_S  <= 1'b0;
                        WREADY_S   <= 1'b1;
                        BID_S      <= AWID_S;
                        aw_len_dbg <= AWLEN_S;
                    end else begin
                        AWREADY_S <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (WVALID_S && WREADY_S && WLAST_S) begin
                        w_state  <= W_RESP;
                        WREADY_S <= 1'b0;
                        BVALID_S <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (BVALID_S && BREADY_S) begin
                        w_state   <= W_IDLE;
                        BVALID_S  <= 1'b0;
                        AWREADY_S <= 1'b1;
                    end
                end
                default: begin
                    w_state   <= W_IDLE;
                    AWREADY_S <= 1'b0;
                    WREADY_S  <= 1'b0;
                    BVALID_S  <= 1'b0;
                end
            endcase
            BRESP_S <= RESP_DECERR;
        end
    end

    // Read side: AR -> ARLEN+1 zero-data DECERR beats. RLAST is precomputed so it is
    // registered alongside RVALID and holds through RREADY stalls.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= R_IDLE;
            ARREADY_S <= 1'b0;
            RVALID_S  <= 1'b0;
            RLAST_S   <= 1'b0;
            RID_S     <= '0;
            RDATA_S   <= '0;
            RRESP_S   <= RESP_DECERR;
            ar_len    <= '0;
            beat_cnt  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID_S && ARREADY_S) begin
                        r_state   <= R_DATA;
                        ARREADY_S <= 1'b0;
                        RVALID_S  <= 1'b1;
                        RID_S     <= ARID_S;
                        ar_len    <= ARLEN_S;
                        beat_cnt  <= '0;
                        RLAST_S   <= (ARLEN_S == '0);
                    end else begin
                        ARREADY_S <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RVALID_S && RREADY_S) begin
                        if (RLAST_S) begin
                            r_state   <= R_IDLE;
                            RVALID_S  <= 1'b0;
                            RLAST_S   <= 1'b0;
                            ARREADY_S <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt_next;
                            RLAST_S  <= (beat_cnt_next == ar_len);
                        end
                    end
                end
                default: begin
                    r_state   <= R_IDLE;
                    ARREADY_S <= 1'b0;
                    RVALID_S  <= 1'b0;
                    RLAST_S   <= 1'b0;
                end
            endcase
            RDATA_S <= '0;
            RRESP_S <= RESP_DECERR;
        end
    end

endmodule
